// File: rtl/mem_stage_lsu_if.sv
// Memory-side bus of the MEM stage: data-RAM port plus the IO request/ack port.
//   master : the load/store unit (drives dm_en/dm_we/dm_addr/dm_wdata and
//            io_req/io_we/io_addr/io_wdata/io_be; receives dm_rdata, io_rdata, io_ack)
//   slave  : the memory / IO fabric (mirror image)
interface mem_stage_lsu_if #(
   parameter int unsigned DM_AW = 12
) ();
   logic             dm_en;
   logic [3:0]       dm_we;
   logic [DM_AW-1:0] dm_addr;
   logic [31:0]      dm_wdata;
   logic [31:0]      dm_rdata;
   logic             io_req;
   logic             io_we;
   logic [29:0]      io_addr;
   logic [31:0]      io_wdata;
   logic [3:0]       io_be;
   logic [31:0]      io_rdata;
   logic             io_ack;

   modport master (
      output dm_en, dm_we, dm_addr, dm_wdata,
      input  dm_rdata,
      output io_req, io_we, io_addr, io_wdata, io_be,
      input  io_rdata, io_ack
   );

   modport slave (
      input  dm_en, dm_we, dm_addr, dm_wdata,
      output dm_rdata,
      input  io_req, io_we, io_addr, io_wdata, io_be,
      output io_rdata, io_ack
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage load/store unit.
// Accepts one op per cycle from EX, routes memory ops to the data RAM
// (addresses below DM_LIMIT) or the IO port, and produces registered WB results.
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   ex_*               : op from EX (held stable while mem_stall=1), flush kills it
//   mem_stall          : back-pressure to EX
//   mem                : data-RAM and IO bus (master side)
//   wb_*               : registered writeback result, wb_exc flags misalignment/IO timeout
module mem_stage_lsu #(
   parameter logic [31:0] DM_LIMIT   = 32'h0000_3000,
   parameter int unsigned DM_AW      = 12,
   parameter int unsigned IO_TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ex_valid,
   input  logic           ex_memRead,
   input  logic           ex_memWrite,
   input  logic [1:0]     ex_size,
   input  logic           ex_signed,
   input  logic [31:0]    ex_addr,
   input  logic [31:0]    ex_wdata,
   input  logic [4:0]     ex_rw,
   input  logic           ex_regWrite,
   input  logic           flush,
   output logic           mem_stall,
   mem_stage_lsu_if.master mem,
   output logic           wb_valid,
   output logic           wb_regWrite,
   output logic [4:0]     wb_rw,
   output logic [31:0]    wb_data,
   output logic           wb_exc
);

   localparam int unsigned CW = $clog2(IO_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DM_RD, IO_WAIT} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // op captured at accept, used once EX may have moved on
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic [1:0]  op_size;
   logic        op_signed;
   logic        op_write;
   logic [4:0]  op_rw;
   logic        op_regwrite;

   logic        is_mem, misaligned, accept, go_mem, in_dm, acc_dm, acc_io;
   logic        io_active, io_timeout;
   logic [31:0] cur_addr, cur_wdata;
   logic [1:0]  cur_size;
   logic        cur_signed, cur_write, cur_regwrite;
   logic [4:0]  cur_rw;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   byte_en = 4'b0001 << off;
         2'b01:   byte_en = 4'b0011 << off;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
      logic [31:0] sh;
      sh = raw >> {off, 3'b000};
      case (size)
         2'b00:   load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
         2'b01:   load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
         default: load_extract = raw;
      endcase
   endfunction

   always_comb begin
      is_mem     = ex_memRead | ex_memWrite;
      misaligned = is_mem && ((ex_size == 2'b01 && ex_addr[0]) ||
                              (ex_size == 2'b10 && ex_addr[1:0] != 2'b00) ||
                              (ex_size == 2'b11));
      accept     = (state == IDLE) && ex_valid && !flush;
      go_mem     = accept && is_mem && !misaligned;
      in_dm      = ex_addr < DM_LIMIT;
      acc_dm     = go_mem && in_dm;
      acc_io     = go_mem && !in_dm;

      // in IDLE the live EX op is used, afterwards the captured copy
      if (state == IDLE) begin
         cur_addr     = ex_addr;
         cur_wdata    = ex_wdata;
         cur_size     = ex_size;
         cur_signed   = ex_signed;
         cur_write    = ex_memWrite;
         cur_rw       = ex_rw;
         cur_regwrite = ex_regWrite;
      end else begin
         cur_addr     = op_addr;
         cur_wdata    = op_wdata;
         cur_size     = op_size;
         cur_signed   = op_signed;
         cur_write    = op_write;
         cur_rw       = op_rw;
         cur_regwrite = op_regwrite;
      end

      io_active  = !flush && (acc_io || state == IO_WAIT);
      // cnt holds the ack-less io_req cycles already elapsed; this is the last allowed one
      io_timeout = io_active && !mem.io_ack && (cnt == CW'(IO_TIMEOUT - 1));

      mem.dm_en    = acc_dm;
      mem.dm_we    = (acc_dm && ex_memWrite) ? byte_en(ex_size, ex_addr[1:0]) : '0;
      mem.dm_addr  = ex_addr[DM_AW+1:2];
      mem.dm_wdata = ex_wdata << {ex_addr[1:0], 3'b000};

      mem.io_req   = io_active;
      mem.io_we    = cur_write;
      mem.io_addr  = cur_addr[31:2];
      mem.io_wdata = cur_wdata << {cur_addr[1:0], 3'b000};
      mem.io_be    = byte_en(cur_size, cur_addr[1:0]);

      mem_stall = (acc_dm && !ex_memWrite) || (io_active && !mem.io_ack && !io_timeout);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         wb_valid    <= 1'b0;
         wb_regWrite <= 1'b0;
         wb_exc      <= 1'b0;
         wb_rw       <= '0;
         wb_data     <= '0;
      end else begin
         wb_valid    <= 1'b0;
         wb_regWrite <= 1'b0;
         wb_exc      <= 1'b0;

         if (accept) begin
            op_addr     <= ex_addr;
            op_wdata    <= ex_wdata;
            op_size     <= ex_size;
            op_signed   <= ex_signed;
            op_write    <= ex_memWrite;
            op_rw       <= ex_rw;
            op_regwrite <= ex_regWrite;
         end

         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (io_active) begin
            // covers both the accept cycle and IO_WAIT; ack beats timeout
            if (mem.io_ack) begin
               wb_valid    <= 1'b1;
               wb_rw       <= cur_rw;
               wb_regWrite <= cur_regwrite;
               wb_data     <= cur_write ? cur_addr
                                        : load_extract(mem.io_rdata, cur_size, cur_addr[1:0], cur_signed);
               state       <= IDLE;
               cnt         <= '0;
            end else if (io_timeout) begin
               wb_valid <= 1'b1;
               wb_exc   <= 1'b1;
               wb_rw    <= cur_rw;
               wb_data  <= cur_addr;
               state    <= IDLE;
               cnt      <= '0;
            end else begin
               state <= IO_WAIT;
               cnt   <= cnt + 1'b1;
            end
         end else if (state == DM_RD) begin
            wb_valid    <= 1'b1;
            wb_rw       <= op_rw;
            wb_regWrite <= op_regwrite;
            wb_data     <= load_extract(mem.dm_rdata, op_size, op_addr[1:0], op_signed);
            state       <= IDLE;
         end else if (accept) begin
            if (go_mem && !ex_memWrite) begin
               state <= DM_RD;
            end else begin
               // non-memory op, DM store or misaligned op completes next cycle
               wb_valid    <= 1'b1;
               wb_rw       <= ex_rw;
               wb_data     <= ex_addr;
               wb_exc      <= misaligned;
               wb_regWrite <= ex_regWrite & ~misaligned;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

   localparam int unsigned T = 16;

   logic        clk, rst;
   logic        ex_valid, ex_memRead, ex_memWrite, ex_signed, ex_regWrite, flush;
   logic [1:0]  ex_size;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rw;
   logic        mem_stall;
   logic        wb_valid, wb_regWrite, wb_exc;
   logic [4:0]  wb_rw;
   logic [31:0] wb_data;

   mem_stage_lsu_if #(.DM_AW(12)) mem_bus ();

   mem_stage_lsu #(
      .DM_LIMIT  (32'h0000_3000),
      .DM_AW     (12),
      .IO_TIMEOUT(T)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_memRead (ex_memRead),
      .ex_memWrite(ex_memWrite),
      .ex_size    (ex_size),
      .ex_signed  (ex_signed),
      .ex_addr    (ex_addr),
      .ex_wdata   (ex_wdata),
      .ex_rw      (ex_rw),
      .ex_regWrite(ex_regWrite),
      .flush      (flush),
      .mem_stall  (mem_stall),
      .mem        (mem_bus),
      .wb_valid   (wb_valid),
      .wb_regWrite(wb_regWrite),
      .wb_rw      (wb_rw),
      .wb_data    (wb_data),
      .wb_exc     (wb_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr, wdata;
      logic [4:0]  rw;
      logic        regw;
      logic [31:0] rdata;
      int          delay;   // cycle index (0 = accept) at which io_ack is raised
   } op_t;

   typedef struct {
      int          stall, ioreq, dmen;
      logic        valid, exc, regw;
      logic [4:0]  rw;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] maddr, lane;
      logic        iowe;
   } res_t;

   typedef struct {
      op_t  op;
      res_t exp;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic op_t mk_op(logic rd, logic wr, logic [1:0] size, logic sgn, logic [31:0] addr,
                                 logic [31:0] wdata, logic [4:0] rw, logic regw, logic [31:0] rdata, int delay);
      op_t o;
      o.rd = rd; o.wr = wr; o.size = size; o.sgn = sgn; o.addr = addr; o.wdata = wdata;
      o.rw = rw; o.regw = regw; o.rdata = rdata; o.delay = delay;
      return o;
   endfunction

   function automatic res_t mk_res(int stall, int ioreq, int dmen, logic valid, logic exc, logic regw,
                                   logic [4:0] rw, logic [31:0] data, logic [3:0] be, logic [31:0] maddr,
                                   logic [31:0] lane, logic iowe);
      res_t r;
      r.stall = stall; r.ioreq = ioreq; r.dmen = dmen; r.valid = valid; r.exc = exc; r.regw = regw;
      r.rw = rw; r.data = data; r.be = be; r.maddr = maddr; r.lane = lane; r.iowe = iowe;
      return r;
   endfunction

   // Reference behaviour of one op, derived from byte counts and offsets.
   function automatic res_t expect_op(op_t op);
      res_t        e;
      int          nb, off;
      logic [31:0] v, mask;
      e = mk_res(0, 0, 0, 1'b1, 1'b0, 1'b0, op.rw, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
      off = int'(op.addr % 4);
      nb  = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : (op.size == 2'd2) ? 4 : 0;
      if (!(op.rd || op.wr)) begin
         e.regw = op.regw;
         e.data = op.addr;
         return e;
      end
      if (nb == 0 || (off % nb) != 0) begin
         e.exc = 1'b1;
         return e;
      end
      for (int i = 0; i < nb; i++) e.be[off + i] = 1'b1;
      e.lane = op.wdata << (8 * off);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      v = (op.rdata >> (8 * off)) & mask;
      if (op.sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      if (op.addr < 32'h3000) begin
         e.dmen  = 1;
         e.maddr = (op.addr / 4) % 4096;
         e.regw  = op.regw;
         if (op.wr) e.data = op.addr;
         else begin
            e.stall = 1;
            e.data  = v;
            e.be    = 4'h0;
         end
      end else begin
         e.maddr = op.addr / 4;
         e.iowe  = op.wr;
         if (op.delay <= int'(T) - 1) begin
            e.ioreq = op.delay + 1;
            e.stall = op.delay;
            e.regw  = op.regw;
            e.data  = op.wr ? op.addr : v;
         end else begin
            e.ioreq = T;
            e.stall = T - 1;
            e.exc   = 1'b1;
         end
      end
      return e;
   endfunction

   // Entered and left at posedge+1; ends once WB of this op is visible.
   task automatic run_op(input op_t op, output res_t r);
      int   k;
      logic stalled, done;
      r = mk_res(0, 0, 0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
      ex_memRead = op.rd; ex_memWrite = op.wr; ex_size = op.size; ex_signed = op.sgn;
      ex_addr = op.addr; ex_wdata = op.wdata; ex_rw = op.rw; ex_regWrite = op.regw;
      mem_bus.dm_rdata = op.rdata; mem_bus.io_rdata = op.rdata;
      ex_valid = 1'b1;
      k = 0; done = 1'b0;
      while (!done && k < 60) begin
         mem_bus.io_ack = (k == op.delay);
         #2;
         if (k == 0) begin
            if (mem_bus.dm_en) begin
               r.be = mem_bus.dm_we; r.maddr = 32'(mem_bus.dm_addr); r.lane = mem_bus.dm_wdata;
            end else if (mem_bus.io_req) begin
               r.be = mem_bus.io_be; r.maddr = 32'(mem_bus.io_addr); r.lane = mem_bus.io_wdata;
               r.iowe = mem_bus.io_we;
            end
         end
         if (mem_bus.dm_en) r.dmen++;
         if (mem_bus.io_req) r.ioreq++;
         stalled = mem_stall;
         if (stalled) r.stall++;
         @(posedge clk); #1;
         k++;
         if (!stalled) done = 1'b1;
      end
      mem_bus.io_ack = 1'b0;
      ex_valid = 1'b0;
      check("op_completes_in_budget", {31'd0, done}, 32'd1);
      r.valid = wb_valid; r.exc = wb_exc; r.regw = wb_regWrite; r.rw = wb_rw; r.data = wb_data;
   endtask

   task automatic compare_res(input string tag, input res_t g, input res_t e, input op_t op);
      check({tag, ".stall"}, g.stall, e.stall);
      check({tag, ".io_req_cycles"}, g.ioreq, e.ioreq);
      check({tag, ".dm_en_cycles"}, g.dmen, e.dmen);
      check({tag, ".wb_valid"}, g.valid, e.valid);
      check({tag, ".wb_exc"}, g.exc, e.exc);
      check({tag, ".wb_regWrite"}, g.regw, e.regw);
      check({tag, ".wb_rw"}, g.rw, e.rw);
      if (!e.exc) check({tag, ".wb_data"}, g.data, e.data);
      if (e.dmen > 0 || e.ioreq > 0) begin
         check({tag, ".be"}, g.be, e.be);
         check({tag, ".maddr"}, g.maddr, e.maddr);
         if (op.wr) check({tag, ".wdata_lane"}, g.lane, e.lane);
      end
      if (e.ioreq > 0) check({tag, ".io_we"}, g.iowe, e.iowe);
   endtask

   function automatic op_t rand_op();
      op_t         o;
      int unsigned kind, sel;
      kind = $urandom_range(0, 2);
      sel  = $urandom_range(0, 3);
      o.rd = (kind == 1); o.wr = (kind == 2);
      o.size = 2'($urandom_range(0, 3));
      o.sgn = 1'($urandom_range(0, 1));
      case (sel)
         0:       o.addr = $urandom_range(0, 32'h2FFF);
         1:       o.addr = $urandom_range(32'h2FF8, 32'h3007);
         2:       o.addr = $urandom;
         default: o.addr = 32'h7F00 + ($urandom & 32'hFF);
      endcase
      if ($urandom_range(0, 3) != 0 && o.size != 2'd3)
         o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
      o.wdata = $urandom; o.rdata = $urandom;
      o.rw = 5'($urandom_range(0, 31));
      o.regw = 1'($urandom_range(0, 1));
      o.delay = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, T));
      return o;
   endfunction

   vec_t vec[13];
   res_t got;
   op_t  op;
   logic [4:0]  hold_rw;
   logic [31:0] hold_data;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec[0]  = '{mk_op(1, 0, 2'd0, 1, 32'h103, 0, 5, 1, 32'h8000_0000, 99),
                  mk_res(1, 0, 1, 1, 0, 1, 5, 32'hFFFF_FF80, 4'h0, 32'h40, 0, 0)};
      vec[1]  = '{mk_op(0, 1, 2'd1, 0, 32'h202, 32'h1234, 0, 0, 0, 99),
                  mk_res(0, 0, 1, 1, 0, 0, 0, 32'h202, 4'hC, 32'h80, 32'h1234_0000, 0)};
      vec[2]  = '{mk_op(1, 0, 2'd2, 0, 32'h7F00, 0, 9, 1, 32'hDEAD_BEEF, 3),
                  mk_res(3, 4, 0, 1, 0, 1, 9, 32'hDEAD_BEEF, 4'hF, 32'h1FC0, 0, 0)};
      vec[3]  = '{mk_op(1, 0, 2'd2, 0, 32'h7F04, 0, 3, 1, 32'h1111_2222, 99),
                  mk_res(15, 16, 0, 1, 1, 0, 3, 0, 4'hF, 32'h1FC1, 0, 0)};
      vec[4]  = '{mk_op(1, 0, 2'd2, 0, 32'h6, 0, 4, 1, 0, 99),
                  mk_res(0, 0, 0, 1, 1, 0, 4, 0, 0, 0, 0, 0)};
      vec[5]  = '{mk_op(0, 0, 2'd3, 0, 32'hCAFE_0001, 0, 31, 1, 0, 99),
                  mk_res(0, 0, 0, 1, 0, 1, 31, 32'hCAFE_0001, 0, 0, 0, 0)};
      vec[6]  = '{mk_op(0, 1, 2'd2, 0, 32'h8000_0010, 32'hA5A5_5A5A, 0, 0, 0, 0),
                  mk_res(0, 1, 0, 1, 0, 0, 0, 32'h8000_0010, 4'hF, 32'h2000_0004, 32'hA5A5_5A5A, 1)};
      vec[7]  = '{mk_op(1, 0, 2'd1, 0, 32'h4002, 0, 2, 1, 32'h8123_4567, 15),
                  mk_res(15, 16, 0, 1, 0, 1, 2, 32'h0000_8123, 4'hC, 32'h1000, 0, 0)};
      vec[8]  = '{mk_op(1, 0, 2'd0, 1, 32'h2FFF, 0, 6, 1, 32'h7F00_0000, 99),
                  mk_res(1, 0, 1, 1, 0, 1, 6, 32'h7F, 4'h0, 32'hBFF, 0, 0)};
      vec[9]  = '{mk_op(0, 1, 2'd0, 0, 32'h3000, 32'hAB, 0, 0, 0, 1),
                  mk_res(1, 2, 0, 1, 0, 0, 0, 32'h3000, 4'h1, 32'hC00, 32'hAB, 1)};
      vec[10] = '{mk_op(1, 0, 2'd3, 0, 32'h100, 0, 8, 1, 0, 99),
                  mk_res(0, 0, 0, 1, 1, 0, 8, 0, 0, 0, 0, 0)};
      vec[11] = '{mk_op(0, 1, 2'd1, 0, 32'h201, 32'h55, 0, 1, 0, 99),
                  mk_res(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
      vec[12] = '{mk_op(1, 0, 2'd1, 1, 32'h10, 0, 13, 1, 32'h1234_F00D, 99),
                  mk_res(1, 0, 1, 1, 0, 1, 13, 32'hFFFF_F00D, 4'h0, 32'h4, 0, 0)};

      rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
      ex_size = 2'd0; ex_signed = 1'b0; ex_addr = '0; ex_wdata = '0; ex_rw = '0; ex_regWrite = 1'b0;
      mem_bus.dm_rdata = '0; mem_bus.io_rdata = '0; mem_bus.io_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; #2;
      check("rst.wb_valid", wb_valid, 0);
      check("rst.wb_regWrite", wb_regWrite, 0);
      check("rst.wb_exc", wb_exc, 0);
      check("rst.wb_rw", wb_rw, 0);
      check("rst.wb_data", wb_data, 0);
      check("rst.mem_stall", mem_stall, 0);
      check("rst.io_req", mem_bus.io_req, 0);
      check("rst.dm_en", mem_bus.dm_en, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         run_op(vec[i].op, got);
         compare_res($sformatf("vec%0d", i), got, vec[i].exp, vec[i].op);
         @(posedge clk); #1;
         check("idle.wb_valid", wb_valid, 0);
         check("idle.wb_regWrite", wb_regWrite, 0);
      end

      // flush in the second IO_WAIT cycle
      op = mk_op(0, 0, 2'd0, 0, 32'h1357_9BDF, 0, 11, 1, 0, 99);
      run_op(op, got);
      compare_res("pre_flush", got, expect_op(op), op);
      ex_memRead = 1'b1; ex_memWrite = 1'b0; ex_size = 2'd2; ex_addr = 32'h7F00;
      ex_rw = 5'd20; ex_regWrite = 1'b1; ex_valid = 1'b1; mem_bus.io_ack = 1'b0;
      #2;
      check("flushseq.accept_io_req", mem_bus.io_req, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1; #2;
      check("flushseq.io_req_in_flush", mem_bus.io_req, 0);
      check("flushseq.stall_in_flush", mem_stall, 0);
      hold_rw = wb_rw; hold_data = wb_data;
      @(posedge clk); #1;
      flush = 1'b0; ex_valid = 1'b0; #2;
      check("flushseq.wb_valid", wb_valid, 0);
      check("flushseq.wb_regWrite", wb_regWrite, 0);
      check("flushseq.wb_exc", wb_exc, 0);
      check("flushseq.wb_rw_hold", wb_rw, 32'(hold_rw));
      check("flushseq.wb_data_hold", wb_data, hold_data);
      check("flushseq.io_req_after", mem_bus.io_req, 0);
      @(posedge clk); #1;
      op = mk_op(0, 0, 2'd0, 0, 32'h2468_ACE0, 0, 12, 1, 0, 99);
      run_op(op, got);
      compare_res("post_flush", got, expect_op(op), op);

      // reset together with flush while waiting on IO
      ex_memRead = 1'b1; ex_memWrite = 1'b0; ex_size = 2'd2; ex_addr = 32'h9000;
      ex_rw = 5'd21; ex_regWrite = 1'b1; ex_valid = 1'b1; mem_bus.io_ack = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2;
      check("rstseq.io_req_waiting", mem_bus.io_req, 1);
      rst = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0; ex_valid = 1'b0; #2;
      check("rstseq.io_req", mem_bus.io_req, 0);
      check("rstseq.mem_stall", mem_stall, 0);
      check("rstseq.wb_data", wb_data, 0);
      check("rstseq.wb_rw", wb_rw, 0);
      check("rstseq.wb_valid", wb_valid, 0);
      check("rstseq.wb_exc", wb_exc, 0);
      @(posedge clk); #1;
      check("rstseq.wb_exc_later", wb_exc, 0);
      check("rstseq.io_req_later", mem_bus.io_req, 0);

      for (int n = 0; n < 300; n++) begin
         op = rand_op();
         run_op(op, got);
         compare_res($sformatf("rnd%0d", n), got, expect_op(op), op);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            check("rnd.idle_wb_valid", wb_valid, 0);
            check("rnd.idle_wb_regWrite", wb_regWrite, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
